// File: rtl/sp_ram_pkg.sv
// Shared types and constants for the pipelined single-port RAM.
package sp_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/sp_ram_core.sv
// Storage array with one synchronous port; rdata only updates on an accepted request.
module sp_ram_core
  import sp_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int DEPTH    = 64,
  parameter int RDW_MODE = RDW_OLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              zero,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Out-of-range requests return zero; rdata holds between requests so q can follow it directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rdata <= '0;
    else if (en) begin
      if (zero)
        rdata <= '0;
      else if (RDW_MODE == RDW_NEW && we)
        rdata <= wdata;
      else
        rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sp_ram_pipelined.sv
// Single-port RAM with valid/ready request port, clear sequencer and optional output register.
module sp_ram_pipelined
  import sp_ram_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 6,
  parameter int                DEPTH     = 64,
  parameter int                OUT_REG   = 1,
  parameter int                RDW_MODE  = RDW_OLD,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] q,
  output logic              busy
);

  localparam int STAGES = 1 + OUT_REG;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              accept, in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, core_rdata;
  logic [STAGES:0]   vld_pipe, err_pipe;
  logic [STAGES:1]   vld_q, err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    busy        = 1'b0;
    req_ready   = 1'b0;
    case (state)
      CLEAR: begin
        busy        = 1'b1;
        clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
          state_nxt   = RUN;
          clr_cnt_nxt = '0;
        end
      end
      RUN: begin
        // clear takes priority over a request in the same cycle
        req_ready = !clear;
        if (clear) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign accept    = req_valid && req_ready;
  assign in_range  = {1'b0, addr} < (ADDR_W + 1)'(DEPTH);
  assign mem_we    = busy || (accept && we && in_range);
  assign mem_addr  = busy ? clr_cnt : addr;
  assign mem_wdata = busy ? CLEAR_VAL : data;

  sp_ram_core #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .RDW_MODE(RDW_MODE)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .zero (!in_range),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(core_rdata)
  );

  // Stage 0 is the acceptance cycle; the response leaves at stage STAGES.
  assign vld_pipe = {vld_q, accept};
  assign err_pipe = {err_q, accept && !in_range};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      err_q <= err_pipe[STAGES-1:0];
    end
  end

  assign rsp_valid = vld_pipe[STAGES];
  assign rsp_err   = vld_pipe[STAGES] && err_pipe[STAGES];

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] q_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          q_reg <= '0;
        else if (vld_pipe[1])
          q_reg <= core_rdata;
      end
      assign q = q_reg;
    end else begin : g_noreg
      assign q = core_rdata;
    end
  endgenerate

endmodule
